// File: rtl/io_port_responder.sv
// Host-side endpoint for the CPU's IN/OUT ports: an input FIFO feeds cpu_in_port and
// advances on each IN consume, an output FIFO captures each OUT writeback for the host.
module io_port_responder #(
  parameter int unsigned        DATA_W     = 16,
  parameter int unsigned        DEPTH      = 8,
  parameter logic [DATA_W-1:0]  DEFAULT_IN = '0,
  localparam int unsigned       CW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_out_port,
  input  logic              cpu_out_strobe,
  output logic [DATA_W-1:0] cpu_in_port,
  input  logic              cpu_in_ack,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [CW-1:0]     in_count,
  output logic [CW-1:0]     out_count,
  output logic              in_underflow,
  output logic              out_overflow,
  input  logic              clear_flags
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] in_mem  [DEPTH];
  logic [DATA_W-1:0] out_mem [DEPTH];
  logic [AW-1:0]     in_wr, in_rd, out_wr, out_rd;
  logic [DATA_W-1:0] last_in;

  logic in_push, in_pop, in_empty, in_full;
  logic out_push, out_pop, out_full;
  logic underflow_evt, overflow_evt;

  always_comb begin
    in_empty      = (in_count == '0);
    in_full       = (in_count == CW'(DEPTH));
    out_full      = (out_count == CW'(DEPTH));
    host_in_ready = !in_full;
    in_push       = host_in_valid && !in_full;
    in_pop        = cpu_in_ack && !in_empty;
    underflow_evt = cpu_in_ack && in_empty;

    host_out_valid = (out_count != '0);
    host_out_data  = out_mem[out_rd];
    out_pop        = host_out_valid && host_out_ready;
    // A strobe into a full FIFO is only safe when the host frees a slot this same edge.
    out_push       = cpu_out_strobe && (!out_full || out_pop);
    overflow_evt   = cpu_out_strobe && out_full && !out_pop;

    cpu_in_port = in_empty ? last_in : in_mem[in_rd];
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= host_in_data;
    if (out_push) out_mem[out_wr] <= cpu_out_port;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr    <= '0;
      in_rd    <= '0;
      in_count <= '0;
      last_in  <= DEFAULT_IN;
    end else begin
      if (in_push) in_wr <= in_wr + AW'(1);
      if (in_pop) begin
        in_rd   <= in_rd + AW'(1);
        last_in <= in_mem[in_rd];
      end
      unique case ({in_push, in_pop})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop)  out_rd <= out_rd + AW'(1);
      unique case ({out_push, out_pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // Set beats clear so an event coinciding with clear_flags is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_underflow <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (underflow_evt)    in_underflow <= 1'b1;
      else if (clear_flags) in_underflow <= 1'b0;
      if (overflow_evt)     out_overflow <= 1'b1;
      else if (clear_flags) out_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_io_port_responder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] cpu_out_port = '0;
  logic              cpu_out_strobe = 1'b0;
  logic [DATA_W-1:0] cpu_in_port;
  logic              cpu_in_ack = 1'b0;
  logic [DATA_W-1:0] host_in_data = '0;
  logic              host_in_valid = 1'b0;
  logic              host_in_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready = 1'b0;
  logic [CW-1:0]     in_count, out_count;
  logic              in_underflow, out_overflow;
  logic              clear_flags = 1'b0;

  int checks = 0;
  int failures = 0;

  io_port_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEFAULT_IN(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .cpu_out_port(cpu_out_port), .cpu_out_strobe(cpu_out_strobe),
    .cpu_in_port(cpu_in_port), .cpu_in_ack(cpu_in_ack),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .in_count(in_count), .out_count(out_count),
    .in_underflow(in_underflow), .out_overflow(out_overflow), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_out_strobe = 1'b0;
    cpu_in_ack     = 1'b0;
    host_in_valid  = 1'b0;
    host_out_ready = 1'b0;
    clear_flags    = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cpu_in_port !== 16'h0000) begin failures++; $display("FAIL reset_in_port got=%h exp=0000", cpu_in_port); end
    checks++; if (in_count !== 4'd0) begin failures++; $display("FAIL reset_in_count got=%0d exp=0", in_count); end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    checks++; if (host_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", host_in_ready); end
    checks++; if (host_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", host_out_valid); end
    checks++; if ({in_underflow, out_overflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {in_underflow, out_overflow}); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_in_port();
    host_in_valid = 1'b1; host_in_data = 16'h0014;
    tick();
    checks++; if (cpu_in_port !== 16'h0014) begin failures++; $display("FAIL in_first_word got=%h exp=0014", cpu_in_port); end
    host_in_data = 16'h0005;
    tick();
    idle();
    checks++; if (in_count !== 4'd2) begin failures++; $display("FAIL in_count2 got=%0d exp=2", in_count); end
    checks++; if (cpu_in_port !== 16'h0014) begin failures++; $display("FAIL in_head got=%h exp=0014", cpu_in_port); end
    cpu_in_ack = 1'b1;
    tick();
    checks++; if (cpu_in_port !== 16'h0005) begin failures++; $display("FAIL in_after_ack1 got=%h exp=0005", cpu_in_port); end
    tick();
    checks++; if (in_count !== 4'd0) begin failures++; $display("FAIL in_count_empty got=%0d exp=0", in_count); end
    checks++; if (cpu_in_port !== 16'h0005) begin failures++; $display("FAIL in_hold_last got=%h exp=0005", cpu_in_port); end
    checks++; if (in_underflow !== 1'b0) begin failures++; $display("FAIL in_no_underflow got=%b exp=0", in_underflow); end
    tick();
    idle();
    checks++; if (in_underflow !== 1'b1) begin failures++; $display("FAIL in_underflow got=%b exp=1", in_underflow); end
    checks++; if (cpu_in_port !== 16'h0005) begin failures++; $display("FAIL in_underflow_hold got=%h exp=0005", cpu_in_port); end
    checks++; if (in_count !== 4'd0) begin failures++; $display("FAIL in_underflow_count got=%0d exp=0", in_count); end
  endtask

  task automatic test_out_port();
    cpu_out_strobe = 1'b1; cpu_out_port = 16'hBEEF;
    tick();
    checks++; if (host_out_valid !== 1'b1) begin failures++; $display("FAIL out_valid_after_strobe got=%b exp=1", host_out_valid); end
    cpu_out_port = 16'h1234;
    tick();
    idle();
    checks++; if (out_count !== 4'd2) begin failures++; $display("FAIL out_count2 got=%0d exp=2", out_count); end
    checks++; if (host_out_data !== 16'hBEEF) begin failures++; $display("FAIL out_head got=%h exp=beef", host_out_data); end
    host_out_ready = 1'b1;
    tick();
    checks++; if (host_out_data !== 16'h1234) begin failures++; $display("FAIL out_second got=%h exp=1234", host_out_data); end
    checks++; if (out_count !== 4'd1) begin failures++; $display("FAIL out_count1 got=%0d exp=1", out_count); end
    tick();
    idle();
    checks++; if (host_out_valid !== 1'b0) begin failures++; $display("FAIL out_drained_valid got=%b exp=0", host_out_valid); end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL out_drained_count got=%0d exp=0", out_count); end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      cpu_out_strobe = 1'b1; cpu_out_port = 16'h1000 + 16'(i);
      tick();
    end
    checks++; if (out_count !== 4'd8) begin failures++; $display("FAIL ovf_full_count got=%0d exp=8", out_count); end
    checks++; if (out_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", out_overflow); end
    cpu_out_port = 16'hDEAD;
    tick();
    checks++; if (out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", out_overflow); end
    checks++; if (out_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", out_count); end
    checks++; if (host_out_data !== 16'h1000) begin failures++; $display("FAIL ovf_head got=%h exp=1000", host_out_data); end
    host_out_ready = 1'b1;
    tick();
    cpu_out_strobe = 1'b0;
    checks++; if (out_count !== 4'd8) begin failures++; $display("FAIL ovf_pop_push_count got=%0d exp=8", out_count); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 16'hDEAD : 16'h1001 + 16'(i);
      checks++; if (host_out_data !== exp) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, host_out_data, exp); end
      tick();
    end
    idle();
    checks++; if (host_out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", host_out_valid); end
  endtask

  task automatic test_reset_mid();
    host_in_valid = 1'b1; host_in_data = 16'h7777;
    cpu_out_strobe = 1'b1; cpu_out_port = 16'h5555;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cpu_in_port !== 16'h0000) begin failures++; $display("FAIL mid_rst_in_port got=%h exp=0000", cpu_in_port); end
    checks++; if ({in_count, out_count} !== 8'h00) begin failures++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", in_count, out_count); end
    checks++; if ({in_underflow, out_overflow} !== 2'b00) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00", {in_underflow, out_overflow}); end
    checks++; if ({host_in_ready, host_out_valid} !== 2'b10) begin failures++; $display("FAIL mid_rst_handshake got=%b exp=10", {host_in_ready, host_out_valid}); end
    idle();
    tick();
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_in_full();
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      host_in_valid = 1'b1; host_in_data = 16'h2000 + 16'(i);
      tick();
    end
    checks++; if (host_in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", host_in_ready); end
    checks++; if (in_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", in_count); end
    host_in_data = 16'hAAAA; cpu_in_ack = 1'b1;
    tick();
    host_in_valid = 1'b0;
    checks++; if (in_count !== 4'd7) begin failures++; $display("FAIL full_push_ack_count got=%0d exp=7", in_count); end
    for (int i = 1; i < 8; i++) begin
      exp = 16'h2000 + 16'(i);
      checks++; if (cpu_in_port !== exp) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, cpu_in_port, exp); end
      tick();
    end
    idle();
    checks++; if (in_count !== 4'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", in_count); end
    checks++; if (cpu_in_port !== 16'h2007) begin failures++; $display("FAIL full_last got=%h exp=2007", cpu_in_port); end
  endtask

  task automatic test_clear_flags();
    cpu_in_ack = 1'b1;
    tick();
    idle();
    checks++; if (in_underflow !== 1'b1) begin failures++; $display("FAIL clr_setup got=%b exp=1", in_underflow); end
    clear_flags = 1'b1; cpu_in_ack = 1'b1; host_in_valid = 1'b1; host_in_data = 16'h3333;
    tick();
    idle();
    checks++; if (in_underflow !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", in_underflow); end
    checks++; if (in_count !== 4'd1) begin failures++; $display("FAIL clr_push_lands got=%0d exp=1", in_count); end
    checks++; if (cpu_in_port !== 16'h3333) begin failures++; $display("FAIL clr_push_word got=%h exp=3333", cpu_in_port); end
    for (int i = 0; i < 9; i++) begin
      cpu_out_strobe = 1'b1; cpu_out_port = 16'h4000 + 16'(i);
      tick();
    end
    idle();
    checks++; if (out_overflow !== 1'b1) begin failures++; $display("FAIL clr_ovf_setup got=%b exp=1", out_overflow); end
    clear_flags = 1'b1;
    tick();
    idle();
    checks++; if ({in_underflow, out_overflow} !== 2'b00) begin failures++; $display("FAIL clr_alone got=%b exp=00", {in_underflow, out_overflow}); end
  endtask

  initial begin
    test_reset();
    test_in_port();
    test_out_port();
    test_overflow();
    test_reset_mid();
    test_in_full();
    test_clear_flags();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
